aes_key_sched: RTL and testbench

AES_KEY_SCHED -- requirements
Module: aes_key_sched

---
 rtl/aes_pkg.sv | 48 ++++
 rtl/aes_key_sched_if.sv | 21 ++
 rtl/aes_subword.sv | 16 +
 rtl/aes_key_sched.sv | 83 ++++++++
 tb/tb_aes_key_sched.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: key-schedule state encoding, round constants and the forward S-box.
// The S-box is also consumed by aes_rounddata.
package aes_pkg;

  typedef enum logic {IDLE, EMIT} ks_state_e;

  // Indexed by round number 1..10; padded to 16 so any 4-bit index is in range.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_key_sched_if.sv
// Key-in / round-key-out handshake bundle of the AES-128 key scheduler.
interface aes_key_sched_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_round;
  logic [127:0] rk_out;
  logic         busy;

  modport master (
    output key_valid, key_in, rk_ready,
    input  key_ready, rk_valid, rk_round, rk_out, busy
  );

  modport slave (
    input  key_valid, key_in, rk_ready,
    output key_ready, rk_valid, rk_round, rk_out, busy
  );
endinterface

// File: rtl/aes_subword.sv
// Combinational AES SubWord: four parallel S-box lookups on a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  always_comb begin
    sub = '0;
    for (int i = 0; i < 4; i++) begin
      sub[i*8 +: 8] = SBOX[word[i*8 +: 8]];
    end
  end

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 key expansion: accepts a cipher key and streams round keys 0..NR over a
// valid/ready handshake, one round key per accepted transfer.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_key_sched_if.slave bus
);

  localparam logic [3:0] LastRound = 4'(NR);

  ks_state_e    state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] key_q, key_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3, sub_w3, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [3:0]   round_nxt;

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w3    = {w3[23:0], w3[31:24]};
  assign round_nxt = round_q + 4'd1;

  aes_subword u_subword (
    .word (rot_w3),
    .sub  (sub_w3)
  );

  assign t  = sub_w3 ^ {RCON[round_nxt], 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    key_d   = key_q;
    unique case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          state_d = EMIT;
          round_d = 4'd0;
          key_d   = bus.key_in;
        end
      end
      EMIT: begin
        // key_valid is deliberately not looked at here; a new key waits for IDLE.
        if (bus.rk_ready) begin
          if (round_q == LastRound) begin
            state_d = IDLE;
          end else begin
            round_d = round_nxt;
            key_d   = {n0, n1, n2, n3};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      key_q   <= key_d;
    end
  end

  assign bus.key_ready = (state_q == IDLE);
  assign bus.rk_valid  = (state_q == EMIT);
  assign bus.busy      = (state_q == EMIT);
  assign bus.rk_round  = round_q;
  assign bus.rk_out    = key_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched: FIPS-197 and all-zero keys, backpressure, busy key,
// mid-expansion reset and back-to-back keys.
module tb_aes_key_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_sched_if bus ();

  aes_key_sched #(.NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FipsKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] OtherKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ZeroR1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZeroR10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [127:0] fips_rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rk(input string tag, input int r, input logic [127:0] exp);
    chk({tag, " rk_valid"}, 128'(bus.rk_valid), 128'(1));
    chk({tag, " rk_round"}, 128'(bus.rk_round), 128'(r));
    chk({tag, " rk_out"}, bus.rk_out, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " rk_valid"}, 128'(bus.rk_valid), 128'(0));
    chk({tag, " key_ready"}, 128'(bus.key_ready), 128'(1));
    chk({tag, " busy"}, 128'(bus.busy), 128'(0));
  endtask

  // Called on a falling edge; returns on the falling edge where round 0 is visible.
  task automatic load_key(input logic [127:0] k);
    bus.key_valid = 1'b1;
    bus.key_in    = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic run_fips(input string tag);
    for (int r = 0; r <= 10; r++) begin
      chk_rk(tag, r, fips_rk[r]);
      @(negedge clk);
    end
    chk_idle({tag, " end"});
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_in    = '0;
    bus.rk_ready  = 1'b0;
    repeat (2) @(negedge clk);

    chk_idle("reset");
    chk("reset rk_round", 128'(bus.rk_round), 128'(0));
    chk("reset rk_out", bus.rk_out, 128'(0));

    // rk_ready while idle must not start anything.
    bus.rk_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("idle rk_ready");

    // Plain FIPS-197 run, 11 consecutive valid cycles.
    load_key(FipsKey);
    chk("fips key_ready", 128'(bus.key_ready), 128'(0));
    chk("fips busy", 128'(bus.busy), 128'(1));
    run_fips("fips");

    // Backpressure at round 5.
    load_key(FipsKey);
    for (int r = 0; r < 5; r++) begin
      chk_rk("bp", r, fips_rk[r]);
      @(negedge clk);
    end
    chk_rk("bp r5", 5, fips_rk[5]);
    bus.rk_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_rk("bp hold", 5, fips_rk[5]);
    end
    bus.rk_ready = 1'b1;
    @(negedge clk);
    for (int r = 6; r <= 10; r++) begin
      chk_rk("bp", r, fips_rk[r]);
      @(negedge clk);
    end
    chk_idle("bp end");

    // Different key offered while busy must be ignored.
    load_key(FipsKey);
    for (int r = 0; r <= 10; r++) begin
      chk_rk("busykey", r, fips_rk[r]);
      if (r == 3) begin
        bus.key_valid = 1'b1;
        bus.key_in    = OtherKey;
      end
      if (r >= 3 && r <= 6) chk("busykey key_ready", 128'(bus.key_ready), 128'(0));
      if (r == 6) bus.key_valid = 1'b0;
      @(negedge clk);
    end
    chk_idle("busykey end");

    // Reset at round 4 aborts the expansion.
    load_key(FipsKey);
    for (int r = 0; r < 4; r++) @(negedge clk);
    chk_rk("rst r4", 4, fips_rk[4]);
    rst_n = 1'b0;
    #1;
    chk_idle("rst async");
    chk("rst rk_round", 128'(bus.rk_round), 128'(0));
    chk("rst rk_out", bus.rk_out, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("rst release");
    load_key(FipsKey);
    run_fips("after rst");

    // Back-to-back: key_valid held across the round-10 handshake.
    load_key(FipsKey);
    for (int r = 0; r <= 10; r++) begin
      chk_rk("b2b", r, fips_rk[r]);
      if (r == 10) begin
        bus.key_valid = 1'b1;
        bus.key_in    = '0;
      end
      @(negedge clk);
    end
    chk_idle("b2b gap");
    @(negedge clk);
    bus.key_valid = 1'b0;
    chk_rk("zero", 0, 128'(0));
    chk("zero key_ready", 128'(bus.key_ready), 128'(0));
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      chk("zero rk_round", 128'(bus.rk_round), 128'(r));
      if (r == 1) chk("zero r1", bus.rk_out, ZeroR1);
      if (r == 10) chk("zero r10", bus.rk_out, ZeroR10);
    end
    @(negedge clk);
    chk_idle("zero end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
